// File: rtl/cond_unit.sv
// cond_unit -- condition-evaluation and flag-register unit.
//
// Evaluates the 4-bit condition field of the current instruction against the
// registered {N,Z,C,V} flags and gates the decoder's branch, register-write
// and memory-write requests. It also updates the flags from the ALU and
// counts valid instructions whose condition failed.
//
// Ports
//   CLK         in   clock, rising edge
//   RESETn      in   asynchronous active-low reset
//   Cond[3:0]   in   condition field
//   ALUFlags    in   {N,Z,C,V} from the ALU
//   FlagW[1:0]  in   [1] write N,Z ; [0] write C,V
//   PCS, RegW, MemW, NoWrite  in  decoder requests
//   InstrValid  in   instruction is real (not a bubble)
//   Stall       in   instruction held by a multi-cycle unit
//   CntClr      in   synchronous clear of SkipCount
//   PCSrc, RegWrite, MemWrite  out  gated enables
//   CondEx      out  condition passes (from registered flags)
//   Flags[3:0]  out  registered {N,Z,C,V}
//   Carry       out  registered C
//   SkipCount   out  saturating count of condition-failed instructions
module cond_unit (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  input  logic        InstrValid,
  input  logic        Stall,
  input  logic        CntClr,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [3:0]  Flags,
  output logic        Carry,
  output logic [15:0] SkipCount
);

  logic [3:0]  r_flags;
  logic [15:0] r_skip;
  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_ex;
  logic        w_go;
  logic        w_exec;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // A bubble is treated exactly like a stall: nothing commits.
  assign w_go   = InstrValid & ~Stall;
  assign w_exec = w_go & w_cond_ex;

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_exec;
  assign RegWrite = RegW & ~NoWrite & w_exec;
  assign MemWrite = MemW & w_exec;

  // Condition uses the pre-update flags; the new values are seen next cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_flags <= '0;
    end else begin
      if (FlagW[1] && w_exec) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && w_exec) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_skip <= '0;
    end else if (CntClr) begin
      r_skip <= '0;
    end else if (w_go && !w_cond_ex && (r_skip != '1)) begin
      r_skip <= r_skip + 16'd1;
    end
  end

  assign Flags     = r_flags;
  assign Carry     = r_flags[1];
  assign SkipCount = r_skip;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic        CLK;
  logic        RESETn;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, NoWrite;
  logic        InstrValid, Stall, CntClr;
  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic        Carry;
  logic [15:0] SkipCount;

  int checks = 0;
  int errors = 0;

  cond_unit dut (
    .CLK(CLK), .RESETn(RESETn), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .InstrValid(InstrValid), .Stall(Stall), .CntClr(CntClr),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Flags(Flags), .Carry(Carry), .SkipCount(SkipCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Cond = 4'b1111; ALUFlags = '0; FlagW = '0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    InstrValid = 0; Stall = 0; CntClr = 0;
  endtask

  // Load flags with an always-executing instruction, then go idle.
  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f; InstrValid = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    RESETn = 0;
    #2;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", Flags); end
    checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", Carry); end
    checks++; if (SkipCount !== 16'h0000) begin errors++; $display("FAIL reset_skip got %h exp 0000", SkipCount); end
    Cond = 4'b0001; #1;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL reset_ne_condex got %b exp 1", CondEx); end
    Cond = 4'b0000; #1;
    checks++; if (CondEx !== 1'b0) begin errors++; $display("FAIL reset_eq_condex got %b exp 0", CondEx); end
    @(negedge CLK);
    RESETn = 1;
    idle();
  endtask

  task automatic test_flag_load();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110; InstrValid = 1;
    tick();
    checks++; if (Flags !== 4'b0110) begin errors++; $display("FAIL load_flags got %b exp 0110", Flags); end
    checks++; if (Carry !== 1'b1) begin errors++; $display("FAIL load_carry got %b exp 1", Carry); end
    Cond = 4'b0000; FlagW = 2'b00; #1;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL load_next_eq got %b exp 1", CondEx); end
    idle();
  endtask

  task automatic test_cond_fail();
    load_flags(4'b0000);
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL fail_preload got %b exp 0000", Flags); end
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1; InstrValid = 1; #1;
    checks++; if (CondEx !== 1'b0) begin errors++; $display("FAIL fail_condex got %b exp 0", CondEx); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL fail_regwrite got %b exp 0", RegWrite); end
    checks++; if (SkipCount !== 16'd0) begin errors++; $display("FAIL fail_skip_before got %h exp 0000", SkipCount); end
    tick();
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL fail_flags_held got %b exp 0000", Flags); end
    checks++; if (SkipCount !== 16'd1) begin errors++; $display("FAIL fail_skip_after got %h exp 0001", SkipCount); end
    idle();
  endtask

  task automatic test_branch();
    load_flags(4'b1000);
    Cond = 4'b1011; PCS = 1; InstrValid = 1; #1;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL lt_taken_condex got %b exp 1", CondEx); end
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL lt_taken_pcsrc got %b exp 1", PCSrc); end
    idle();
    load_flags(4'b1001);
    Cond = 4'b1011; PCS = 1; InstrValid = 1; #1;
    checks++; if (CondEx !== 1'b0) begin errors++; $display("FAIL lt_nt_condex got %b exp 0", CondEx); end
    checks++; if (PCSrc !== 1'b0) begin errors++; $display("FAIL lt_nt_pcsrc got %b exp 0", PCSrc); end
    tick();
    checks++; if (SkipCount !== 16'd2) begin errors++; $display("FAIL lt_nt_skip got %h exp 0002", SkipCount); end
    idle();
  endtask

  task automatic test_enables();
    Cond = 4'b1110; InstrValid = 1; PCS = 1; RegW = 1; MemW = 1; NoWrite = 1; #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL nowrite_regwrite got %b exp 0", RegWrite); end
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL en_memwrite got %b exp 1", MemWrite); end
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL en_pcsrc got %b exp 1", PCSrc); end
    NoWrite = 0; #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL en_regwrite got %b exp 1", RegWrite); end
    InstrValid = 0; #1;
    checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin errors++; $display("FAIL bubble_enables got %b exp 000", {PCSrc, RegWrite, MemWrite}); end
    idle();
  endtask

  task automatic test_partial();
    load_flags(4'b0011);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0100; InstrValid = 1;
    tick();
    checks++; if (Flags !== 4'b0111) begin errors++; $display("FAIL flagw10 got %b exp 0111", Flags); end
    FlagW = 2'b01; ALUFlags = 4'b1010;
    tick();
    checks++; if (Flags !== 4'b0110) begin errors++; $display("FAIL flagw01 got %b exp 0110", Flags); end
    checks++; if (Carry !== 1'b1) begin errors++; $display("FAIL flagw01_carry got %b exp 1", Carry); end
    idle();
  endtask

  task automatic test_pre_update();
    load_flags(4'b0100);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0000; InstrValid = 1; #1;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL preupd_condex got %b exp 1", CondEx); end
    tick();
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL preupd_flags got %b exp 0000", Flags); end
    FlagW = 2'b00; InstrValid = 0; #1;
    checks++; if (CondEx !== 1'b0) begin errors++; $display("FAIL preupd_next got %b exp 0", CondEx); end
    idle();
  endtask

  task automatic test_decode();
    logic [3:0]  fv   [5];
    logic [15:0] mask [5];
    logic [15:0] m;
    fv[0] = 4'b0000; mask[0] = 16'h56AA;
    fv[1] = 4'b0110; mask[1] = 16'h66A5;
    fv[2] = 4'b1011; mask[2] = 16'h5556;
    fv[3] = 4'b1000; mask[3] = 16'h6A9A;
    fv[4] = 4'b0001; mask[4] = 16'h6A6A;
    for (int i = 0; i < 5; i++) begin
      load_flags(fv[i]);
      m = mask[i];
      for (int c = 0; c < 16; c++) begin
        Cond = c[3:0]; #1;
        checks++;
        if (CondEx !== m[c]) begin
          errors++;
          $display("FAIL decode flags=%b cond=%b got %b exp %b", fv[i], Cond, CondEx, m[c]);
        end
      end
    end
    idle();
  endtask

  task automatic test_stall();
    CntClr = 1;
    tick();
    CntClr = 0;
    checks++; if (SkipCount !== 16'd0) begin errors++; $display("FAIL clr_skip got %h exp 0000", SkipCount); end
    Stall = 1; InstrValid = 1; Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b1111;
    PCS = 1; RegW = 1; MemW = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin errors++; $display("FAIL stall_enables got %b exp 000", {PCSrc, RegWrite, MemWrite}); end
      checks++; if (CondEx !== 1'b0) begin errors++; $display("FAIL stall_condex got %b exp 0", CondEx); end
      tick();
      checks++; if (Flags !== 4'b0001) begin errors++; $display("FAIL stall_flags got %b exp 0001", Flags); end
      checks++; if (SkipCount !== 16'd0) begin errors++; $display("FAIL stall_skip got %h exp 0000", SkipCount); end
    end
    Cond = 4'b1110; #1;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL stall_al_condex got %b exp 1", CondEx); end
    checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin errors++; $display("FAIL stall_al_enables got %b exp 000", {PCSrc, RegWrite, MemWrite}); end
    tick();
    checks++; if (Flags !== 4'b0001) begin errors++; $display("FAIL stall_al_flags got %b exp 0001", Flags); end
    Stall = 0; InstrValid = 0; #1;
    checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin errors++; $display("FAIL bubble_al_enables got %b exp 000", {PCSrc, RegWrite, MemWrite}); end
    tick();
    checks++; if (Flags !== 4'b0001) begin errors++; $display("FAIL bubble_flags got %b exp 0001", Flags); end
    idle();
  endtask

  task automatic test_saturate();
    Cond = 4'b1111; InstrValid = 1;
    for (int k = 0; k < 65535; k++) tick();
    checks++; if (SkipCount !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", SkipCount); end
    tick();
    checks++; if (SkipCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", SkipCount); end
    CntClr = 1;
    tick();
    checks++; if (SkipCount !== 16'h0000) begin errors++; $display("FAIL clr_priority got %h exp 0000", SkipCount); end
    idle();
  endtask

  task automatic test_reset_mid();
    Cond = 4'b1111; InstrValid = 1;
    for (int k = 0; k < 3; k++) tick();
    checks++; if (SkipCount !== 16'd3) begin errors++; $display("FAIL pre_rst_skip got %h exp 0003", SkipCount); end
    idle();
    load_flags(4'b1110);
    checks++; if (Flags !== 4'b1110) begin errors++; $display("FAIL pre_rst_flags got %b exp 1110", Flags); end
    Stall = 1; InstrValid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0001; PCS = 1;
    #2;
    RESETn = 0;
    #1;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL async_rst_flags got %b exp 0000", Flags); end
    checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL async_rst_carry got %b exp 0", Carry); end
    checks++; if (SkipCount !== 16'd0) begin errors++; $display("FAIL async_rst_skip got %h exp 0000", SkipCount); end
    Cond = 4'b1111; #1;
    checks++; if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin errors++; $display("FAIL async_rst_outs got %b exp 0000", {CondEx, PCSrc, RegWrite, MemWrite}); end
    Cond = 4'b0001; #1;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL rst_ne_condex got %b exp 1", CondEx); end
    tick();
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL rst_edge_flags got %b exp 0000", Flags); end
    @(negedge CLK);
    RESETn = 1;
    idle();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010; InstrValid = 1;
    tick();
    checks++; if (Flags !== 4'b1010) begin errors++; $display("FAIL post_rst_flags got %b exp 1010", Flags); end
    checks++; if (SkipCount !== 16'd0) begin errors++; $display("FAIL post_rst_skip got %h exp 0000", SkipCount); end
    idle();
  endtask

  initial begin
    test_reset();
    test_flag_load();
    test_cond_fail();
    test_branch();
    test_enables();
    test_partial();
    test_pre_update();
    test_decode();
    test_stall();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
